// File: rtl/aes_pkg.sv
// Shared AES types and byte/word helpers used by the round-key scheduler.
package aes_pkg;

  typedef logic [127:0] aes_128;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Consumer-facing bundle of the round-key scheduler: control/key in, round key out.
interface aes_key_sched_if import aes_pkg::*; ();

  logic       start_i;
  aes_128     key_i;
  logic       next_i;
  aes_128     rnd_key_o;
  logic [3:0] rnd_idx_o;
  logic       key_valid_o;
  logic       zero_rnd_o;
  logic       final_rnd_o;
  logic       done_o;

  modport master (
    output start_i, key_i, next_i,
    input  rnd_key_o, rnd_idx_o, key_valid_o, zero_rnd_o, final_rnd_o, done_o
  );

  modport slave (
    input  start_i, key_i, next_i,
    output rnd_key_o, rnd_idx_o, key_valid_o, zero_rnd_o, final_rnd_o, done_o
  );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: forward S-box on each byte of a 32-bit word.
module aes_sub_word import aes_pkg::*; (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word[31:24] = sbox(i_word[31:24]);
  assign o_word[23:16] = sbox(i_word[23:16]);
  assign o_word[15:8]  = sbox(i_word[15:8]);
  assign o_word[7:0]   = sbox(i_word[7:0]);

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 on-the-fly round-key generator: one expanded round key per next_i request.
module aes_key_sched import aes_pkg::*; #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       nrst,
  aes_key_sched_if.slave bus
);

  ks_state_e   r_state;
  ks_state_e   w_state_nxt;
  aes_128      r_key;
  aes_128      w_key_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [7:0]  r_rcon;
  logic [7:0]  w_rcon_nxt;
  logic        r_done;
  logic        w_done_nxt;

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;
  aes_128      w_expanded;
  logic        w_last;
  logic        w_advance;

  assign w_rot = rot_word(r_key[31:0]);

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_t        = w_sub ^ {r_rcon, 24'h000000};
  assign w_w0       = r_key[127:96] ^ w_t;
  assign w_w1       = r_key[95:64]  ^ w_w0;
  assign w_w2       = r_key[63:32]  ^ w_w1;
  assign w_w3       = r_key[31:0]   ^ w_w2;
  assign w_expanded = {w_w0, w_w1, w_w2, w_w3};

  assign w_last    = (r_idx == 4'(NR));
  assign w_advance = (r_state == ACTIVE) && bus.next_i;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_rcon  <= RCON_INIT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_idx   <= w_idx_nxt;
      r_rcon  <= w_rcon_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.start_i) begin
      w_state_nxt = ACTIVE;
    end else if (w_advance && w_last) begin
      w_state_nxt = IDLE;
    end
  end

  // start_i wins over next_i; the final request retires the schedule but keeps the last key visible.
  always_comb begin
    w_key_nxt  = r_key;
    w_idx_nxt  = r_idx;
    w_rcon_nxt = r_rcon;
    w_done_nxt = 1'b0;
    if (bus.start_i) begin
      w_key_nxt  = bus.key_i;
      w_idx_nxt  = 4'd0;
      w_rcon_nxt = RCON_INIT;
    end else if (w_advance) begin
      if (w_last) begin
        w_done_nxt = 1'b1;
      end else begin
        w_key_nxt  = w_expanded;
        w_idx_nxt  = r_idx + 4'd1;
        w_rcon_nxt = xtime(r_rcon);
      end
    end
  end

  assign bus.rnd_key_o   = r_key;
  assign bus.rnd_idx_o   = r_idx;
  assign bus.key_valid_o = (r_state == ACTIVE);
  assign bus.zero_rnd_o  = (r_state == ACTIVE) && (r_idx == 4'd0);
  assign bus.final_rnd_o = (r_state == ACTIVE) && w_last;
  assign bus.done_o      = r_done;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 AES-128 key-expansion vectors.
module tb_aes_key_sched;
  import aes_pkg::*;

  localparam aes_128 K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_128 K_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_128 K_A2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam aes_128 K_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_128 K_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_128 K_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  aes_key_sched_if bus ();

  aes_key_sched #(.NR(10)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    bus.next_i = 1'b1;
    cyc();
    bus.next_i = 1'b0;
  endtask

  task automatic do_start(input aes_128 k);
    bus.start_i = 1'b1;
    bus.key_i   = k;
    cyc();
    bus.start_i = 1'b0;
  endtask

  // {valid, zero, final, done} packed for compact flag checks
  function automatic logic [3:0] flags();
    return {bus.key_valid_o, bus.zero_rnd_o, bus.final_rnd_o, bus.done_o};
  endfunction

  initial begin
    nrst        = 1'b0;
    bus.start_i = 1'b0;
    bus.next_i  = 1'b0;
    bus.key_i   = '0;
    #3;
    chk("reset_key",   bus.rnd_key_o, 128'h0);
    chk("reset_idx",   128'(bus.rnd_idx_o), 128'd0);
    chk("reset_flags", 128'(flags()), 128'h0);
    cyc();
    cyc();
    nrst = 1'b1;
    cyc();

    pulse_next();
    chk("idle_next_flags", 128'(flags()), 128'h0);
    chk("idle_next_key",   bus.rnd_key_o, 128'h0);

    do_start(K_A);
    chk("start_key",   bus.rnd_key_o, K_A);
    chk("start_idx",   128'(bus.rnd_idx_o), 128'd0);
    chk("start_flags", 128'(flags()), 128'b1100);

    pulse_next();
    chk("r1_key",   bus.rnd_key_o, K_A1);
    chk("r1_idx",   128'(bus.rnd_idx_o), 128'd1);
    chk("r1_flags", 128'(flags()), 128'b1000);

    bus.key_i = ~K_A;
    pulse_next();
    chk("r2_key", bus.rnd_key_o, K_A2);
    bus.key_i = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    repeat (3) cyc();
    chk("hold_key_toggle", bus.rnd_key_o, K_A2);
    chk("hold_idx",        128'(bus.rnd_idx_o), 128'd2);

    for (int i = 3; i <= 10; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      pulse_next();
      chk("step_idx", 128'(bus.rnd_idx_o), 128'(i));
    end
    chk("r10_key",   bus.rnd_key_o, K_A10);
    chk("r10_flags", 128'(flags()), 128'b1010);
    repeat (4) cyc();
    chk("r10_hold", bus.rnd_key_o, K_A10);

    pulse_next();
    chk("done_flags", 128'(flags()), 128'b0001);
    chk("done_key",   bus.rnd_key_o, K_A10);
    chk("done_idx",   128'(bus.rnd_idx_o), 128'd10);
    cyc();
    chk("done_single", 128'(flags()), 128'b0000);
    pulse_next();
    chk("post_done_idle", 128'(flags()), 128'b0000);

    do_start(K_A);
    repeat (5) pulse_next();
    chk("mid_idx5", 128'(bus.rnd_idx_o), 128'd5);
    bus.next_i = 1'b1;
    do_start(K_B);
    bus.next_i = 1'b0;
    chk("prio_key",   bus.rnd_key_o, K_B);
    chk("prio_idx",   128'(bus.rnd_idx_o), 128'd0);
    chk("prio_flags", 128'(flags()), 128'b1100);
    pulse_next();
    chk("b1_key", bus.rnd_key_o, K_B1);

    repeat (6) pulse_next();
    chk("pre_rst_idx7", 128'(bus.rnd_idx_o), 128'd7);
    #2 nrst = 1'b0;
    #1;
    chk("arst_key",   bus.rnd_key_o, 128'h0);
    chk("arst_idx",   128'(bus.rnd_idx_o), 128'd0);
    chk("arst_flags", 128'(flags()), 128'h0);
    #2 nrst = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      pulse_next();
      chk("post_rst_ignored", {bus.rnd_key_o[123:0], flags()}, 128'h0);
    end

    do_start(K_A);
    chk("restart_key",   bus.rnd_key_o, K_A);
    chk("restart_flags", 128'(flags()), 128'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
